// File: rtl/rotary_quad_decoder_pkg.sv
// rtl/rotary_quad_decoder_pkg.sv - shared FSM states, direction codes and defaults for the rotary encoder decoder.
package rotary_quad_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CW1  = 3'd1,
    S_CW2  = 3'd2,
    S_CW3  = 3'd3,
    S_CCW1 = 3'd4,
    S_CCW2 = 3'd5,
    S_CCW3 = 3'd6
  } rot_state_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // 100 us of stability at a 50 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 5000;

  // Quadrature pairs are always written {a,b}.
  localparam logic [1:0] PAIR_00 = 2'b00;
  localparam logic [1:0] PAIR_01 = 2'b01;
  localparam logic [1:0] PAIR_10 = 2'b10;
  localparam logic [1:0] PAIR_11 = 2'b11;

endpackage

// File: rtl/rotary_quad_decoder_debounce_filter.sv
// rtl/rotary_quad_decoder_debounce_filter.sv - two-flop synchroniser followed by a stable-count filter for one asynchronous input pin.
module debounce_filter
  import rotary_quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DB_CNT_W        = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                deb_q,   deb_d;
  logic [DB_CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    // Any sample that agrees with the accepted level restarts the stability window.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/rotary_quad_decoder.sv
// rtl/rotary_quad_decoder.sv - debounced quadrature rotary encoder decoder producing step events, a wrapping position count and a push-button press pulse.
module rotary_quad_decoder
  import rotary_quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DB_CNT_W        = 13,
  parameter int POS_W           = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ROT_A,
  input  logic             ROT_B,
  input  logic             ROT_CENTER,
  output logic             oRotEvent,
  output logic             oRotDir,
  output logic [POS_W-1:0] oPosition,
  output logic             oCenterPress,
  output logic             oCenterLevel
);

  logic a_deb, b_deb, center_deb;
  logic [1:0] pair;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_deb_a (
    .clk (Clock),
    .rst (Reset),
    .din (ROT_A),
    .dout(a_deb)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_deb_b (
    .clk (Clock),
    .rst (Reset),
    .din (ROT_B),
    .dout(b_deb)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_deb_center (
    .clk (Clock),
    .rst (Reset),
    .din (ROT_CENTER),
    .dout(center_deb)
  );

  assign pair = {a_deb, b_deb};

  rot_state_e       state_q,       state_d;
  logic             rot_event_q,   rot_event_d;
  logic             rot_dir_q,     rot_dir_d;
  logic [POS_W-1:0] position_q,    position_d;
  logic             center_prev_q, center_prev_d;
  logic             press_q,       press_d;

  // Unlisted pairs, including two-bit jumps, leave the state untouched.
  always_comb begin
    state_d     = state_q;
    rot_event_d = 1'b0;
    rot_dir_d   = rot_dir_q;
    position_d  = position_q;
    case (state_q)
      S_IDLE: begin
        if (pair == PAIR_10)      state_d = S_CW1;
        else if (pair == PAIR_01) state_d = S_CCW1;
      end
      S_CW1: begin
        if (pair == PAIR_11)      state_d = S_CW2;
        else if (pair == PAIR_00) state_d = S_IDLE;
      end
      S_CW2: begin
        if (pair == PAIR_01)      state_d = S_CW3;
        else if (pair == PAIR_10) state_d = S_CW1;
      end
      S_CW3: begin
        if (pair == PAIR_00) begin
          state_d     = S_IDLE;
          rot_event_d = 1'b1;
          rot_dir_d   = DIR_CW;
          position_d  = position_q + POS_W'(1);
        end else if (pair == PAIR_11) begin
          state_d = S_CW2;
        end
      end
      S_CCW1: begin
        if (pair == PAIR_11)      state_d = S_CCW2;
        else if (pair == PAIR_00) state_d = S_IDLE;
      end
      S_CCW2: begin
        if (pair == PAIR_10)      state_d = S_CCW3;
        else if (pair == PAIR_01) state_d = S_CCW1;
      end
      S_CCW3: begin
        if (pair == PAIR_00) begin
          state_d     = S_IDLE;
          rot_event_d = 1'b1;
          rot_dir_d   = DIR_CCW;
          position_d  = position_q - POS_W'(1);
        end else if (pair == PAIR_11) begin
          state_d = S_CCW2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    center_prev_d = center_deb;
    press_d       = center_deb & ~center_prev_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      rot_event_q   <= 1'b0;
      rot_dir_q     <= 1'b0;
      position_q    <= '0;
      center_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rot_event_q   <= rot_event_d;
      rot_dir_q     <= rot_dir_d;
      position_q    <= position_d;
      center_prev_q <= center_prev_d;
      press_q       <= press_d;
    end
  end

  assign oRotEvent    = rot_event_q;
  assign oRotDir      = rot_dir_q;
  assign oPosition    = position_q;
  assign oCenterPress = press_q;
  assign oCenterLevel = center_deb;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb/tb_rotary_quad_decoder.sv - directed self-checking bench for rotary_quad_decoder.
module tb_rotary_quad_decoder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ROT_A = 1'b0;
  logic       ROT_B = 1'b0;
  logic       ROT_CENTER = 1'b0;
  logic       oRotEvent;
  logic       oRotDir;
  logic [7:0] oPosition;
  logic       oCenterPress;
  logic       oCenterLevel;

  int n_cmp  = 0;
  int n_fail = 0;
  int ev_cnt = 0;
  int press_cnt = 0;

  rotary_quad_decoder #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W       (3),
    .POS_W          (8)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ROT_A       (ROT_A),
    .ROT_B       (ROT_B),
    .ROT_CENTER  (ROT_CENTER),
    .oRotEvent   (oRotEvent),
    .oRotDir     (oRotDir),
    .oPosition   (oPosition),
    .oCenterPress(oCenterPress),
    .oCenterLevel(oCenterLevel)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oRotEvent)    ev_cnt++;
    if (oCenterPress) press_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_pair(input logic a, input logic b, input int cycles);
    @(negedge Clock);
    ROT_A = a;
    ROT_B = b;
    repeat (cycles) @(negedge Clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    n_cmp++;
    if ({oRotEvent, oRotDir, oPosition, oCenterPress, oCenterLevel} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000", {oRotEvent, oRotDir, oPosition, oCenterPress, oCenterLevel});
    end
    Reset = 1'b0;
    repeat (100) @(negedge Clock);
    n_cmp++;
    if ({oRotEvent, oRotDir, oPosition, oCenterPress, oCenterLevel} !== 12'h000) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h want 000", {oRotEvent, oRotDir, oPosition, oCenterPress, oCenterLevel});
    end
    n_cmp++;
    if (ev_cnt + press_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_pulses: got %0d want 0", ev_cnt + press_cnt);
    end
  endtask

  task automatic test_cw_step();
    int lat;
    int ev0;
    ev0 = ev_cnt;
    lat = -1;
    drive_pair(1'b1, 1'b0, 20);
    drive_pair(1'b1, 1'b1, 20);
    drive_pair(1'b0, 1'b1, 20);
    @(negedge Clock);
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clock);
      if (oRotEvent && lat < 0) lat = i;
    end
    n_cmp++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL cw_latency: got %0d want 7", lat);
    end
    n_cmp++;
    if (ev_cnt - ev0 !== 1) begin
      n_fail++;
      $display("FAIL cw_event_count: got %0d want 1", ev_cnt - ev0);
    end
    n_cmp++;
    if (oRotDir !== 1'b1) begin
      n_fail++;
      $display("FAIL cw_dir: got %b want 1", oRotDir);
    end
    n_cmp++;
    if (oPosition !== 8'd1) begin
      n_fail++;
      $display("FAIL cw_position: got %0d want 1", oPosition);
    end
  endtask

  task automatic test_ccw_steps();
    logic [7:0] exp_pos [3];
    int ev0;
    exp_pos[0] = 8'd0;
    exp_pos[1] = 8'd255;
    exp_pos[2] = 8'd254;
    for (int s = 0; s < 3; s++) begin
      ev0 = ev_cnt;
      drive_pair(1'b0, 1'b1, 20);
      drive_pair(1'b1, 1'b1, 20);
      drive_pair(1'b1, 1'b0, 20);
      drive_pair(1'b0, 1'b0, 20);
      n_cmp++;
      if (ev_cnt - ev0 !== 1) begin
        n_fail++;
        $display("FAIL ccw_event_count[%0d]: got %0d want 1", s, ev_cnt - ev0);
      end
      n_cmp++;
      if (oPosition !== exp_pos[s]) begin
        n_fail++;
        $display("FAIL ccw_position[%0d]: got %0d want %0d", s, oPosition, exp_pos[s]);
      end
      n_cmp++;
      if (oRotDir !== 1'b0) begin
        n_fail++;
        $display("FAIL ccw_dir[%0d]: got %b want 0", s, oRotDir);
      end
    end
  endtask

  task automatic test_backout_glitch();
    int ev0;
    ev0 = ev_cnt;
    drive_pair(1'b1, 1'b0, 20);
    drive_pair(1'b0, 1'b0, 20);
    n_cmp++;
    if (ev_cnt - ev0 !== 0 || oPosition !== 8'd254) begin
      n_fail++;
      $display("FAIL backout: events %0d pos %0d want 0 events pos 254", ev_cnt - ev0, oPosition);
    end
    drive_pair(1'b1, 1'b0, 2);
    drive_pair(1'b0, 1'b0, 20);
    n_cmp++;
    if (ev_cnt - ev0 !== 0 || oPosition !== 8'd254) begin
      n_fail++;
      $display("FAIL glitch: events %0d pos %0d want 0 events pos 254", ev_cnt - ev0, oPosition);
    end
    // A CCW step only decodes correctly if the glitch left the FSM in idle.
    drive_pair(1'b0, 1'b1, 20);
    drive_pair(1'b1, 1'b1, 20);
    drive_pair(1'b1, 1'b0, 20);
    drive_pair(1'b0, 1'b0, 20);
    n_cmp++;
    if (ev_cnt - ev0 !== 1 || oPosition !== 8'd253) begin
      n_fail++;
      $display("FAIL after_glitch_step: events %0d pos %0d want 1 event pos 253", ev_cnt - ev0, oPosition);
    end
  endtask

  task automatic test_center();
    int p0;
    logic lvl5;
    logic lvl6;
    p0 = press_cnt;
    @(negedge Clock) ROT_CENTER = 1'b1;
    @(negedge Clock) ROT_CENTER = 1'b0;
    @(negedge Clock) ROT_CENTER = 1'b1;
    repeat (50) @(negedge Clock);
    n_cmp++;
    if (press_cnt - p0 !== 1) begin
      n_fail++;
      $display("FAIL center_press_count: got %0d want 1", press_cnt - p0);
    end
    n_cmp++;
    if (oCenterLevel !== 1'b1) begin
      n_fail++;
      $display("FAIL center_level_held: got %b want 1", oCenterLevel);
    end
    ROT_CENTER = 1'b0;
    repeat (5) @(negedge Clock);
    lvl5 = oCenterLevel;
    @(negedge Clock);
    lvl6 = oCenterLevel;
    n_cmp++;
    if ({lvl5, lvl6} !== 2'b10) begin
      n_fail++;
      $display("FAIL center_release_timing: got %b%b want 10", lvl5, lvl6);
    end
    repeat (20) @(negedge Clock);
    n_cmp++;
    if (press_cnt - p0 !== 1) begin
      n_fail++;
      $display("FAIL center_release_press: got %0d want 1", press_cnt - p0);
    end
  endtask

  task automatic test_simultaneous();
    int both;
    both = 0;
    drive_pair(1'b1, 1'b0, 20);
    drive_pair(1'b1, 1'b1, 20);
    drive_pair(1'b0, 1'b1, 20);
    @(negedge Clock);
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    ROT_CENTER = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clock);
      if (oRotEvent && oCenterPress) both++;
    end
    n_cmp++;
    if (both !== 1) begin
      n_fail++;
      $display("FAIL simultaneous_pulses: got %0d coincident cycles want 1", both);
    end
    n_cmp++;
    if (oPosition !== 8'd254) begin
      n_fail++;
      $display("FAIL simultaneous_position: got %0d want 254", oPosition);
    end
    ROT_CENTER = 1'b0;
    repeat (20) @(negedge Clock);
  endtask

  task automatic test_reset_mid_rotation();
    int ev0;
    drive_pair(1'b1, 1'b0, 20);
    drive_pair(1'b1, 1'b1, 20);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    ev0 = ev_cnt;
    n_cmp++;
    if (oPosition !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_position: got %0d want 0", oPosition);
    end
    repeat (20) @(negedge Clock);
    drive_pair(1'b0, 1'b0, 20);
    n_cmp++;
    if (ev_cnt - ev0 !== 0 || oPosition !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_no_event: events %0d pos %0d want 0 events pos 0", ev_cnt - ev0, oPosition);
    end
    drive_pair(1'b1, 1'b0, 20);
    drive_pair(1'b1, 1'b1, 20);
    drive_pair(1'b0, 1'b1, 20);
    drive_pair(1'b0, 1'b0, 20);
    n_cmp++;
    if (ev_cnt - ev0 !== 1 || oPosition !== 8'd1 || oRotDir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_recover: events %0d pos %0d dir %b want 1 event pos 1 dir 1", ev_cnt - ev0, oPosition, oRotDir);
    end
  endtask

  initial begin
    test_reset();
    test_cw_step();
    test_ccw_steps();
    test_backout_glitch();
    test_center();
    test_simultaneous();
    test_reset_mid_rotation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
